// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: operation codes, FSM state
// encoding, NOP constants and small decode helpers used by the stage and its
// load-alignment sub-module.
package mem_access_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_LL  = 8'hF0;
  localparam logic [7:0] OP_SC  = 8'hF8;

  localparam logic [4:0]  NOP_REG   = 5'd0;
  localparam logic [31:0] ZERO_WORD = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL,
      OP_SB, OP_SH, OP_SW, OP_SC: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW, OP_SC: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH:      return off[0];
      OP_LW, OP_LL, OP_SW, OP_SC: return |off;
      default:                   return 1'b0;
    endcase
  endfunction

  // Byte lane (0 = bits 7:0) holding the byte at the given address offset.
  // Big-endian puts offset 0 in the most significant lane.
  function automatic logic [1:0] byte_lane(input logic [1:0] off, input logic big_endian);
    return big_endian ? ~off : off;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Picks the addressed byte or halfword out of a bus read word and sign- or
// zero-extends it according to the load operation; word loads pass through.
module load_align
  import mem_access_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [7:0]  aluop,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [1:0]  lane;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane extraction followed by extension selected by the load type
  always_comb begin
    lane     = byte_lane(offset, BIG_ENDIAN);
    byte_val = rdata[{lane, 3'b000} +: 8];
    half_val = rdata[{lane[1], 4'b0000} +: 16];
    case (aluop)
      OP_LB:   data = {{24{byte_val[7]}}, byte_val};
      OP_LBU:  data = {24'd0, byte_val};
      OP_LH:   data = {{16{half_val[15]}}, half_val};
      OP_LHU:  data = {16'd0, half_val};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Non-memory results pass straight through;
// memory operations run one registered bus transaction through an
// IDLE/BUSY/DONE sequence while holding the pipeline via stallreq.
module mem_access
  import mem_access_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  stall,
  input  logic        flush,
  input  logic [4:0]  i_wd,
  input  logic        i_wreg,
  input  logic [31:0] i_wdata,
  input  logic [7:0]  i_aluop,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_reg2,
  input  logic        llbit_in,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic        bus_stb,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_LLbit_we,
  output logic        mem_LLbit_value,
  output logic        stallreq,
  output logic        excp_misalign
);

  state_t      state;
  logic [31:0] rdata_q;
  logic [7:0]  op_q;
  logic [4:0]  wd_q;
  logic [1:0]  off_q;
  logic [31:0] load_data;

  logic        mem_op;
  logic        misalign;
  logic        sc_fail;
  logic        start;
  logic [1:0]  req_lane;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic        unused_stall;

  assign mem_op       = is_mem_op(i_aluop);
  assign misalign     = is_misaligned(i_aluop, i_mem_addr[1:0]);
  assign sc_fail      = (i_aluop == OP_SC) && !llbit_in;
  assign start        = mem_op && !misalign && !sc_fail && !flush;
  assign unused_stall = ^{stall[4], stall[2:0]};

  // Byte enables and lane-replicated store data for the request about to issue
  always_comb begin
    req_lane  = byte_lane(i_mem_addr[1:0], BIG_ENDIAN);
    req_sel   = 4'b1111;
    req_wdata = ZERO_WORD;
    case (i_aluop)
      OP_LB, OP_LBU: req_sel = 4'b0001 << req_lane;
      OP_LH, OP_LHU: req_sel = 4'b0011 << {req_lane[1], 1'b0};
      OP_SB: begin
        req_sel   = 4'b0001 << req_lane;
        req_wdata = {4{i_reg2[7:0]}};
      end
      OP_SH: begin
        req_sel   = 4'b0011 << {req_lane[1], 1'b0};
        req_wdata = {2{i_reg2[15:0]}};
      end
      OP_SW, OP_SC: req_wdata = i_reg2;
      default: ;
    endcase
  end

  // Bus transaction sequencer with registered bus request and read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bus_addr  <= ZERO_WORD;
      bus_wdata <= ZERO_WORD;
      bus_we    <= 1'b0;
      bus_sel   <= 4'd0;
      bus_stb   <= 1'b0;
      rdata_q   <= ZERO_WORD;
      op_q      <= OP_NOP;
      wd_q      <= NOP_REG;
      off_q     <= 2'd0;
    end else if (flush) begin
      state   <= ST_IDLE;
      bus_stb <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus_addr  <= {i_mem_addr[31:2], 2'b00};
            bus_sel   <= req_sel;
            bus_we    <= is_store(i_aluop);
            bus_wdata <= req_wdata;
            bus_stb   <= 1'b1;
            op_q      <= i_aluop;
            wd_q      <= i_wd;
            off_q     <= i_mem_addr[1:0];
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            bus_stb <= 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!stall[3]) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  load_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_load_align (
    .aluop  (op_q),
    .offset (off_q),
    .rdata  (rdata_q),
    .data   (load_data)
  );

  // Stage results toward MEM_WB; reset and flush read as a NOP
  always_comb begin
    mem_wd          = NOP_REG;
    mem_wreg        = 1'b0;
    mem_wdata       = ZERO_WORD;
    mem_LLbit_we    = 1'b0;
    mem_LLbit_value = 1'b0;
    stallreq        = 1'b0;
    excp_misalign   = 1'b0;
    if (!rst && !flush) begin
      case (state)
        ST_IDLE: begin
          if (!mem_op) begin
            mem_wd    = i_wd;
            mem_wreg  = i_wreg;
            mem_wdata = i_wdata;
          end else if (misalign) begin
            mem_wd        = i_wd;
            excp_misalign = 1'b1;
          end else if (sc_fail) begin
            mem_wd   = i_wd;
            mem_wreg = 1'b1;
          end else begin
            stallreq = 1'b1;
          end
        end
        ST_BUSY: stallreq = 1'b1;
        ST_DONE: begin
          mem_wd = wd_q;
          case (op_q)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
              mem_wreg  = 1'b1;
              mem_wdata = load_data;
            end
            OP_LL: begin
              mem_wreg        = 1'b1;
              mem_wdata       = load_data;
              mem_LLbit_we    = 1'b1;
              mem_LLbit_value = 1'b1;
            end
            OP_SC: begin
              mem_wreg     = 1'b1;
              mem_wdata    = 32'd1;
              mem_LLbit_we = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access (big-endian lane order): reset values,
// a table of directed vectors, LL/SC, flush and reset mid-transaction, then
// random operations checked against a behavioural model of the stage.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk, rst, flush, i_wreg, llbit_in;
  logic [4:0]  stall, i_wd;
  logic [31:0] i_wdata, i_mem_addr, i_reg2;
  logic [7:0]  i_aluop;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_stb, bus_ack;
  logic [3:0]  bus_sel;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_LLbit_we, mem_LLbit_value, stallreq, excp_misalign;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          stall;
    logic        stb;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic        we;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        llwe;
    logic        llval;
    logic        excp;
    logic        done;
  } res_t;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] wdata_in;
    logic        llbit;
    logic [31:0] rdata;
    int          waitc;
    int          exp_stall;
    logic        exp_stb;
    logic [3:0]  exp_sel;
    logic [31:0] exp_bwdata;
    logic        exp_we;
    logic        exp_wreg;
    logic [31:0] exp_wdata;
    logic        exp_excp;
  } vec_t;

  vec_t vecs[13];

  mem_access #(.BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .i_wd(i_wd), .i_wreg(i_wreg), .i_wdata(i_wdata), .i_aluop(i_aluop),
    .i_mem_addr(i_mem_addr), .i_reg2(i_reg2), .llbit_in(llbit_in),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_stb(bus_stb), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
    .stallreq(stallreq), .excp_misalign(excp_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: what the stage should do for one operation, from the
  // access size, address offset and big-endian byte numbering.
  function automatic res_t model(input logic [7:0] op, input logic [31:0] addr, reg2, wdata_in,
                                 input logic wreg_in, input logic [4:0] wd, input logic llbit,
                                 input logic [31:0] rdata, input int waitc);
    res_t e;
    int n, k, pos;
    logic is_load, is_st;
    logic [31:0] mask, field;
    e = '{default: 0};
    e.done = 1'b1;
    is_load = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL};
    is_st   = op inside {OP_SB, OP_SH, OP_SW, OP_SC};
    e.wd = wd;
    if (!is_load && !is_st) begin
      e.wreg = wreg_in;
      e.wdata = wdata_in;
      return e;
    end
    n = (op inside {OP_LB, OP_LBU, OP_SB}) ? 1 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2 : 4;
    k = int'(addr % 4);
    if ((addr % n) != 0) begin
      e.excp = 1'b1;
      return e;
    end
    if (op == OP_SC && !llbit) begin
      e.wreg = 1'b1;
      e.wdata = 32'd0;
      return e;
    end
    e.stall = 2 + waitc;
    e.stb   = 1'b1;
    e.addr  = addr - (addr % 4);
    e.we    = is_st;
    pos     = 8 * (4 - k - n);
    e.sel   = 4'(((1 << n) - 1) << (4 - k - n));
    mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    if (is_st)
      e.bwdata = (n == 1) ? 32'(reg2[7:0]) * 32'h0101_0101 :
                 (n == 2) ? 32'(reg2[15:0]) * 32'h0001_0001 : reg2;
    if (is_load) begin
      field = (rdata >> pos) & mask;
      if ((op == OP_LB || op == OP_LH) && field[8 * n - 1]) field = field | ~mask;
      e.wreg  = 1'b1;
      e.wdata = field;
    end
    if (op == OP_LL) begin
      e.llwe = 1'b1;
      e.llval = 1'b1;
    end
    if (op == OP_SC) begin
      e.wreg = 1'b1;
      e.wdata = 32'd1;
      e.llwe = 1'b1;
    end
    return e;
  endfunction

  // Runs one operation from IDLE, acting as the bus slave (ack after waitc
  // wait cycles), and records what the stage did. Starts/ends at posedge+1.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, reg2, wdata_in,
                               input logic wreg_in, input logic [4:0] wd, input logic llbit,
                               input logic [31:0] rdata, input int waitc, output res_t o);
    int busy = 0;
    o = '{default: 0};
    i_aluop = op; i_mem_addr = addr; i_reg2 = reg2; i_wdata = wdata_in;
    i_wreg = wreg_in; i_wd = wd; llbit_in = llbit; bus_rdata = rdata; bus_ack = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus_stb) begin
        busy++;
        o.stb = 1'b1; o.addr = bus_addr; o.sel = bus_sel; o.we = bus_we; o.bwdata = bus_wdata;
      end
      if (excp_misalign) o.excp = 1'b1;
      if (!stallreq) begin
        o.done = 1'b1; o.wd = mem_wd; o.wreg = mem_wreg; o.wdata = mem_wdata;
        o.llwe = mem_LLbit_we; o.llval = mem_LLbit_value;
        break;
      end
      o.stall++;
      bus_ack = (busy > waitc);
    end
    bus_ack = 1'b0;
    i_aluop = OP_NOP; i_wreg = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic compareRes(input string tag, input res_t e, input res_t o);
    checkOutput({tag, " completes"}, 32'(o.done), 32'(e.done));
    checkOutput({tag, " stall cycles"}, o.stall, e.stall);
    checkOutput({tag, " excp_misalign"}, 32'(o.excp), 32'(e.excp));
    checkOutput({tag, " bus_stb seen"}, 32'(o.stb), 32'(e.stb));
    if (e.stb && o.stb) begin
      checkOutput({tag, " bus_addr"}, o.addr, e.addr);
      checkOutput({tag, " bus_sel"}, 32'(o.sel), 32'(e.sel));
      checkOutput({tag, " bus_we"}, 32'(o.we), 32'(e.we));
      if (e.we) checkOutput({tag, " bus_wdata"}, o.bwdata, e.bwdata);
    end
    checkOutput({tag, " mem_wreg"}, 32'(o.wreg), 32'(e.wreg));
    if (e.wreg) begin
      checkOutput({tag, " mem_wd"}, 32'(o.wd), 32'(e.wd));
      checkOutput({tag, " mem_wdata"}, o.wdata, e.wdata);
    end
    checkOutput({tag, " LLbit_we"}, 32'(o.llwe), 32'(e.llwe));
    if (e.llwe) checkOutput({tag, " LLbit_value"}, 32'(o.llval), 32'(e.llval));
  endtask

  initial begin
    res_t o, e;
    logic [7:0] op_list[11];
    logic [7:0] op;
    logic [31:0] addr;

    op_list = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_SB, OP_SH, OP_SW, OP_SC, 8'h25};

    //          op      addr       reg2          wdata_in      ll rdata         w  stl stb sel     bwdata        we wreg wdata         excp
    vecs[0]  = '{OP_LW,  32'h100, 32'h0,        32'h0,        0, 32'h12345678, 1, 3, 1, 4'b1111, 32'h0,        0, 1, 32'h12345678, 0};
    vecs[1]  = '{OP_LB,  32'h103, 32'h0,        32'h0,        0, 32'h000000F0, 0, 2, 1, 4'b0001, 32'h0,        0, 1, 32'hFFFFFFF0, 0};
    vecs[2]  = '{OP_LBU, 32'h103, 32'h0,        32'h0,        0, 32'h000000F0, 0, 2, 1, 4'b0001, 32'h0,        0, 1, 32'h000000F0, 0};
    vecs[3]  = '{OP_SH,  32'h102, 32'h0000ABCD, 32'h0,        0, 32'h0,        0, 2, 1, 4'b0011, 32'hABCDABCD, 1, 0, 32'h0,        0};
    vecs[4]  = '{OP_LW,  32'h102, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 0, 32'h0,        1};
    vecs[5]  = '{OP_LH,  32'h102, 32'h0,        32'h0,        0, 32'h12348001, 0, 2, 1, 4'b0011, 32'h0,        0, 1, 32'hFFFF8001, 0};
    vecs[6]  = '{OP_LHU, 32'h100, 32'h0,        32'h0,        0, 32'h80011234, 2, 4, 1, 4'b1100, 32'h0,        0, 1, 32'h00008001, 0};
    vecs[7]  = '{OP_SB,  32'h101, 32'h1234565A, 32'h0,        0, 32'h0,        0, 2, 1, 4'b0100, 32'h5A5A5A5A, 1, 0, 32'h0,        0};
    vecs[8]  = '{8'h25,  32'h0,   32'h0,        32'hDEADBEEF, 0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 1, 32'hDEADBEEF, 0};
    vecs[9]  = '{OP_LB,  32'h100, 32'h0,        32'h0,        0, 32'h80000000, 3, 5, 1, 4'b1000, 32'h0,        0, 1, 32'hFFFFFF80, 0};
    vecs[10] = '{OP_SW,  32'h104, 32'hCAFEF00D, 32'h0,        0, 32'h0,        2, 4, 1, 4'b1111, 32'hCAFEF00D, 1, 0, 32'h0,        0};
    vecs[11] = '{OP_LH,  32'h101, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 0, 32'h0,        1};
    vecs[12] = '{OP_SC,  32'h108, 32'h11111111, 32'h0,        0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 1, 32'h0,        0};

    // Reset with a live pass-through op on the inputs: outputs must read NOP
    rst = 1'b1; flush = 1'b0; stall = 5'd0; bus_ack = 1'b0; bus_rdata = 32'hA5A5A5A5;
    i_aluop = 8'h25; i_wreg = 1'b1; i_wd = 5'd9; i_wdata = 32'hFFFFFFFF;
    i_mem_addr = 32'h0; i_reg2 = 32'h0; llbit_in = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset mem_wd", 32'(mem_wd), 32'd0);
    checkOutput("reset mem_wreg", 32'(mem_wreg), 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset stallreq", 32'(stallreq), 32'd0);
    checkOutput("reset bus_stb", 32'(bus_stb), 32'd0);
    checkOutput("reset bus_sel", 32'(bus_sel), 32'd0);
    checkOutput("reset bus_addr", bus_addr, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].wdata_in, 1'b1, 5'd7,
                    vecs[i].llbit, vecs[i].rdata, vecs[i].waitc, o);
      e = '{default: 0};
      e.done = 1'b1; e.stall = vecs[i].exp_stall; e.stb = vecs[i].exp_stb;
      e.addr = {vecs[i].addr[31:2], 2'b00}; e.sel = vecs[i].exp_sel; e.we = vecs[i].exp_we;
      e.bwdata = vecs[i].exp_bwdata; e.wd = 5'd7; e.wreg = vecs[i].exp_wreg;
      e.wdata = vecs[i].exp_wdata; e.excp = vecs[i].exp_excp;
      compareRes($sformatf("vec%0d", i), e, o);
    end

    // LL then SC with the link intact, then SC with the link lost
    applyStimulus(OP_LL, 32'h200, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0BADF00D, 0, o);
    compareRes("ll", model(OP_LL, 32'h200, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0BADF00D, 0), o);
    applyStimulus(OP_SC, 32'h200, 32'h55AA55AA, 32'h0, 1'b1, 5'd4, 1'b1, 32'h0, 1, o);
    compareRes("sc ok", model(OP_SC, 32'h200, 32'h55AA55AA, 32'h0, 1'b1, 5'd4, 1'b1, 32'h0, 1), o);
    checkOutput("sc ok mem_wdata", o.wdata, 32'd1);
    applyStimulus(OP_SC, 32'h200, 32'h55AA55AA, 32'h0, 1'b1, 5'd4, 1'b0, 32'h0, 0, o);
    checkOutput("sc fail bus_stb", 32'(o.stb), 32'd0);
    checkOutput("sc fail mem_wdata", o.wdata, 32'd0);
    checkOutput("sc fail mem_wreg", 32'(o.wreg), 32'd1);

    // Flush while BUSY, then an ack arriving after the flush
    i_aluop = OP_LW; i_mem_addr = 32'h300; i_wd = 5'd5; i_wreg = 1'b1; bus_ack = 1'b0;
    @(negedge clk);
    checkOutput("flush idle stallreq", 32'(stallreq), 32'd1);
    @(negedge clk);
    checkOutput("flush busy bus_stb", 32'(bus_stb), 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush mem_wreg", 32'(mem_wreg), 32'd0);
    checkOutput("flush stallreq", 32'(stallreq), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; i_aluop = OP_NOP; i_wreg = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h77777777;
    @(negedge clk);
    checkOutput("post flush bus_stb", 32'(bus_stb), 32'd0);
    checkOutput("post flush stallreq", 32'(stallreq), 32'd0);
    checkOutput("post flush mem_wreg", 32'(mem_wreg), 32'd0);
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    @(negedge clk);
    checkOutput("late ack ignored stallreq", 32'(stallreq), 32'd0);
    checkOutput("late ack ignored bus_stb", 32'(bus_stb), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(OP_LW, 32'h304, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0, 32'h01020304, 0, o);
    compareRes("after flush", model(OP_LW, 32'h304, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0, 32'h01020304, 0), o);

    // Reset while BUSY abandons the transaction
    i_aluop = OP_LW; i_mem_addr = 32'h400; i_wd = 5'd8; i_wreg = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre reset bus_stb", 32'(bus_stb), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid reset bus_stb", 32'(bus_stb), 32'd0);
    checkOutput("mid reset bus_addr", bus_addr, 32'd0);
    checkOutput("mid reset stallreq", 32'(stallreq), 32'd0);
    checkOutput("mid reset mem_wreg", 32'(mem_wreg), 32'd0);
    @(negedge clk);
    rst = 1'b0; i_aluop = OP_NOP; i_wreg = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(OP_LW, 32'h400, 32'h0, 32'h0, 1'b1, 5'd8, 1'b0, 32'hFEEDFACE, 1, o);
    compareRes("after reset", model(OP_LW, 32'h400, 32'h0, 32'h0, 1'b1, 5'd8, 1'b0, 32'hFEEDFACE, 1), o);

    // Random operations against the model
    for (int r = 0; r < 40; r++) begin
      logic [31:0] reg2, wdi, rd;
      logic wr, ll;
      logic [4:0] wd;
      int w;
      op = op_list[$urandom_range(0, 10)];
      addr = 32'($urandom) & 32'h0000_0FFF;
      if ($urandom_range(0, 2) != 0) addr = addr & ~32'h3;
      reg2 = $urandom; wdi = $urandom; rd = $urandom;
      wr = 1'($urandom_range(0, 1)); ll = 1'($urandom_range(0, 1));
      wd = 5'($urandom); w = $urandom_range(0, 3);
      applyStimulus(op, addr, reg2, wdi, wr, wd, ll, rd, w, o);
      compareRes($sformatf("rnd%0d op%02h addr%03h", r, op, addr),
                 model(op, addr, reg2, wdi, wr, wd, ll, rd, w), o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 1, byte-lane order (1: address offset 0 is sel[3]).
REQ-002 SHALL have ports clk in 1 (system clock, rising edge) and rst in 1 (asynchronous, active-high reset).
REQ-003 SHALL have ports stall in 5 (ctrl stall vector, bit 3 is this stage) and flush in 1 (exception flush).
REQ-004 SHALL have inputs i_wd 5, i_wreg 1 and i_wdata 32 (destination, write enable, ALU result), all from EX_MEM.
REQ-005 SHALL have inputs i_aluop 8 (operation), i_mem_addr 32 (effective address) and i_reg2 32 (store data / merge source).
REQ-006 SHALL have input llbit_in 1 (current LLbit, already forwarded from WB).
REQ-007 SHALL have outputs bus_addr 32, bus_wdata 32, bus_we 1, bus_sel 4 and bus_stb 1 (registered bus request).
REQ-008 SHALL have inputs bus_rdata 32 and bus_ack 1 (bus read data and acknowledge).
REQ-009 SHALL have outputs mem_wd 5, mem_wreg 1, mem_wdata 32, mem_LLbit_we 1 and mem_LLbit_value 1, all to MEM_WB.
REQ-010 SHALL have outputs stallreq 1 (to ctrl) and excp_misalign 1 (address error, to exception logic).

Function
REQ-011 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-012 Non-memory aluop: outputs SHALL equal i_* combinationally, stallreq=0, no bus cycle.
REQ-013 Memory ops: LB, LBU, LH, LHU, LW, LL, SB, SH, SW, SC.
REQ-014 IDLE + memory op + aligned + flush=0: stallreq=1 that cycle; next edge registers bus_addr={addr[31:2],2'b00}, bus_sel, bus_we, bus_wdata, bus_stb=1 and enters BUSY.
REQ-015 BUSY: stallreq=1 and bus_stb held; on bus_ack=1, capture bus_rdata, drop bus_stb and enter DONE at the next edge.
REQ-016 DONE: stallreq=0 and outputs SHALL present the captured result; go to IDLE when stall[3]=0, else hold.
REQ-017 Minimum memory-op occupancy: 3 cycles (IDLE, BUSY with ack, DONE); each wait cycle without ack adds 1.
REQ-018 Byte/half stores: bus_wdata SHALL replicate the datum across lanes; bus_sel is one-hot (byte) or a pair (half), as selected by addr[1:0] and BIG_ENDIAN.
REQ-019 Loads: LB/LH SHALL sign-extend and LBU/LHU zero-extend the selected lane; LW/LL return the full word.
REQ-020 Misalignment (half with addr[0]=1; word/LL/SC with addr[1:0]!=0): excp_misalign=1, mem_wreg=0, no bus cycle, stallreq=0.
REQ-021 LL: mem_LLbit_we=1 and mem_LLbit_value=1 in DONE.
REQ-022 SC with llbit_in=1: word store; in DONE mem_wdata=1, mem_wreg=1, mem_LLbit_we=1 and mem_LLbit_value=0.
REQ-023 SC with llbit_in=0: no bus cycle, zero latency, mem_wdata=0, mem_wreg=1 and mem_LLbit_we=0.
REQ-024 Stores (except SC) SHALL force mem_wreg=0.
REQ-025 mem_LLbit_we SHALL be 0 in every other case.
REQ-026 flush=1 in any state: next state IDLE, bus_stb=0, pending ack ignored, outputs forced to NOP (mem_wreg=0, mem_LLbit_we=0).
REQ-027 bus_ack while not BUSY SHALL be ignored.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE and set bus_stb, bus_we, bus_sel, bus_addr, bus_wdata and the captured data register to 0.
REQ-029 During rst=1, combinational outputs SHALL read as NOP: mem_wd=0, mem_wreg=0, mem_wdata=0, LLbit outputs 0, stallreq=0, excp_misalign=0.
REQ-030 Reset during BUSY SHALL abandon the bus cycle; the first op after release restarts from IDLE.

Structure
REQ-031 aluop codes, the FSM state encoding and NOP constants SHALL live in the shared defines package.
REQ-032 Lane selection plus sign/zero extension SHALL be the combinational sub-module load_align.

Verification
REQ-033 LW addr 0x100, ack on 2nd BUSY cycle, rdata 0x12345678 -> stallreq high 3 cycles, then mem_wdata=0x12345678, mem_wreg=1.
REQ-034 LB addr 0x103, rdata 0x000000F0, BIG_ENDIAN=1 -> bus_sel=0001, mem_wdata=0xFFFFFFF0; same stimulus with LBU -> 0x000000F0.
REQ-035 SH addr 0x102, reg2 0x0000ABCD -> bus_sel=0011, bus_wdata=0xABCDABCD, bus_we=1, mem_wreg=0.
REQ-036 LL addr 0x200, then SC with llbit_in=1 -> SC store issued, mem_wdata=1, LLbit_we=1/value=0; SC with llbit_in=0 -> no bus_stb, mem_wdata=0.
REQ-037 LW addr 0x102 -> excp_misalign=1, bus_stb never rises, stallreq=0.
REQ-038 flush in BUSY, then late ack -> IDLE next cycle, bus_stb=0, ack ignored, mem_wreg=0.
